// File: rtl/apb_spi_regs.sv
// APB register bank for the SPI engine: TX/RX data registers, transfer launch
// FSM, and APB wait-state insertion while a transfer is in flight.
// Optional: define SPI_REGS_TIMEOUT_EN to abort accesses stalled for 255 cycles.
module apb_spi_regs #(
  parameter int DWIDTH            = 8,
  parameter int REGN              = 6,
  parameter int REGTX_ADDR_OFFSET = 1,
  localparam int NTX              = REGTX_ADDR_OFFSET + 1,
  localparam int NRX              = REGN - 2 - NTX
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DWIDTH-1:0]     PWDATA,
  input  logic [REGN-1:0]       pselw,
  input  logic                  dec_err,
  output logic [DWIDTH-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [NTX*DWIDTH-1:0] spi_tx_data,
  output logic                  spi_start,
  input  logic                  spi_busy,
  input  logic                  spi_done,
  input  logic [NRX*DWIDTH-1:0] spi_rx_data
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  state_t                         state;
  logic [NTX-1:0][DWIDTH-1:0]     tx_q;
  logic [NRX-1:0][DWIDTH-1:0]     rx_q;
  logic [REGN-3:0]                sel;
  logic                           tx_flag, rx_flag;
  logic                           access, err, stall_raw, stall, timeout;
  logic                           wr_commit, launch;
  logic [DWIDTH-1:0]              rd_mux;

  assign sel     = pselw[REGN-3:0];
  assign tx_flag = pselw[REGN-2];
  assign rx_flag = pselw[REGN-1];
  assign access  = PSEL && PENABLE && !PRESET;

  // Errors: decoder miss, write into the read-only RX group, or a malformed
  // select (multi-hot data field, or group flag with no data register).
  assign err = dec_err || (PWRITE && rx_flag) ||
               ((sel != '0) && !$onehot(sel)) ||
               ((sel == '0) && (tx_flag || rx_flag));

  // Only accesses that touch a register group the transfer owns must wait.
  assign stall_raw = access && !err && (state != S_IDLE) &&
                     ((!PWRITE && rx_flag) || (PWRITE && tx_flag));
  assign stall     = stall_raw && !timeout;

`ifdef SPI_REGS_TIMEOUT_EN
  logic [7:0] to_cnt;
  assign timeout = stall_raw && (to_cnt == 8'hFF);
  // Count consecutive stalled cycles of the current access.
  always_ff @(posedge PCLK) begin
    if (PRESET || !stall_raw || timeout) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign wr_commit = access && PWRITE && !stall && !err && !timeout;
  assign launch    = wr_commit && sel[REGTX_ADDR_OFFSET] && (state == S_IDLE);

  // Read mux; an all-zero select reads engine busy status in bit 0.
  always_comb begin
    rd_mux = '0;
    if (sel == '0) rd_mux[0] = spi_busy;
    for (int i = 0; i < NTX; i++) if (sel[i]) rd_mux |= tx_q[i];
    for (int j = 0; j < NRX; j++) if (sel[NTX+j]) rd_mux |= rx_q[j];
  end

  assign PREADY      = !stall;
  assign PSLVERR     = access && !stall && (err || timeout);
  assign PRDATA      = (access && !err && !timeout) ? rd_mux : '0;
  assign spi_tx_data = tx_q;

  // TX register writes.
  always_ff @(posedge PCLK) begin
    if (PRESET) tx_q <= '0;
    else for (int i = 0; i < NTX; i++) if (wr_commit && sel[i]) tx_q[i] <= PWDATA;
  end

  // Transfer FSM: launch pulse, wait for done, capture RX data.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_IDLE;
      spi_start <= 1'b0;
      rx_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (launch) begin
          state     <= S_START;
          spi_start <= 1'b1;
        end
        S_START: begin
          spi_start <= 1'b0;
          if (spi_done) begin
            rx_q  <= spi_rx_data;
            state <= S_IDLE;
          end else state <= S_BUSY;
        end
        S_BUSY: if (spi_done) begin
          rx_q  <= spi_rx_data;
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          spi_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_regs.sv
// Randomized self-checking bench for apb_spi_regs against a register/transfer model.
module tb_apb_spi_regs;
  localparam int DW = 8, REGN = 6, NTX = 2, NRX = 2;

  logic PCLK = 0, PRESET = 1, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [DW-1:0] PWDATA = 0, PRDATA;
  logic [REGN-1:0] pselw = 0;
  logic dec_err = 0, PREADY, PSLVERR, spi_start, spi_busy = 0, spi_done = 0;
  logic [NTX*DW-1:0] spi_tx_data;
  logic [NRX*DW-1:0] spi_rx_data = 0;

  apb_spi_regs #(.DWIDTH(DW), .REGN(REGN), .REGTX_ADDR_OFFSET(1)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .pselw(pselw), .dec_err(dec_err), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .spi_tx_data(spi_tx_data), .spi_start(spi_start), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data));

  always #5 PCLK = ~PCLK;

  int tests = 0, fails = 0, start_cnt = 0;
  logic [DW-1:0] m_tx [NTX];
  logic [DW-1:0] m_rx [NRX];

  always @(negedge PCLK) if (spi_start === 1'b1) start_cnt++;

  function automatic logic [REGN-1:0] sel_of(input int idx);
    logic [REGN-1:0] s;
    s = '0;
    s[idx] = 1'b1;
    if (idx < NTX) s[REGN-2] = 1'b1; else s[REGN-1] = 1'b1;
    return s;
  endfunction

  function automatic logic [DW-1:0] model_rd(input int idx);
    return (idx < NTX) ? m_tx[idx] : m_rx[idx-NTX];
  endfunction

  // One APB transfer: setup, access, wait for PREADY (bounded).
  task automatic apb(input logic w, input logic [REGN-1:0] s, input logic de, input logic [DW-1:0] wd,
                     output logic [DW-1:0] rd, output logic e, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = w; pselw = s; dec_err = de; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY === 1'b1) break;
      waits++;
      if (waits > 2000) begin
        tests++; fails++;
        $display("FAIL apb_timeout: PREADY stuck at %b, required 1", PREADY);
        break;
      end
    end
    rd = PRDATA; e = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; pselw = '0; dec_err = 0;
  endtask

  task automatic spi_complete(input logic [NRX*DW-1:0] d);
    spi_rx_data = d; spi_done = 1;
    @(posedge PCLK); #1;
    spi_done = 0;
    m_rx[0] = d[DW-1:0]; m_rx[1] = d[2*DW-1:DW];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NTX; i++) m_tx[i] = '0;
    for (int i = 0; i < NRX; i++) m_rx[i] = '0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd; logic e; int w;
    PRESET = 1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;
    model_reset();
    @(negedge PCLK);
    tests++; if (PREADY !== 1'b1) begin fails++; $display("FAIL rst_pready: got %b need 1", PREADY); end
    tests++; if (PSLVERR !== 1'b0) begin fails++; $display("FAIL rst_pslverr: got %b need 0", PSLVERR); end
    tests++; if (PRDATA !== '0) begin fails++; $display("FAIL rst_prdata: got %h need 00", PRDATA); end
    tests++; if (spi_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b need 0", spi_start); end
    tests++; if (spi_tx_data !== '0) begin fails++; $display("FAIL rst_txdata: got %h need 0000", spi_tx_data); end
    foreach (m_tx[i]) ;
    for (int idx = 0; idx < 4; idx += 2) begin
      apb(0, sel_of(idx), 0, 0, rd, e, w);
      tests++; if (rd !== 8'h00 || e !== 1'b0 || w != 0)
        begin fails++; $display("FAIL rst_read%0d: got rd=%h err=%b waits=%0d need 00/0/0", idx, rd, e, w); end
    end
  endtask

  task automatic test_launch();
    logic [DW-1:0] rd; logic e; int w;
    start_cnt = 0;
    apb(1, sel_of(0), 0, 8'hA5, rd, e, w); m_tx[0] = 8'hA5;
    tests++; if (spi_start !== 1'b0) begin fails++; $display("FAIL launch_reg0_nostart: got %b need 0", spi_start); end
    apb(1, sel_of(1), 0, 8'h3C, rd, e, w); m_tx[1] = 8'h3C;
    tests++; if (spi_start !== 1'b1) begin fails++; $display("FAIL launch_pulse: got %b need 1", spi_start); end
    @(posedge PCLK); #1;
    tests++; if (spi_start !== 1'b0) begin fails++; $display("FAIL launch_pulse_end: got %b need 0", spi_start); end
    repeat (3) @(posedge PCLK); #1;
    tests++; if (start_cnt != 1) begin fails++; $display("FAIL launch_count: got %0d need 1", start_cnt); end
    tests++; if (spi_tx_data !== 16'h3CA5) begin fails++; $display("FAIL launch_txdata: got %h need 3ca5", spi_tx_data); end
    spi_complete(16'h0000);
  endtask

  // Stalled access racing a done pulse k cycles after launch: expect k-1 waits.
  task automatic test_stall(input logic w_op, input int idx, input logic [15:0] rxd, input int k, input string nm);
    logic [DW-1:0] rd, wd; logic e; int w;
    wd = 8'($urandom);
    apb(1, sel_of(1), 0, m_tx[1], rd, e, w);
    fork
      apb(w_op, sel_of(idx), 0, wd, rd, e, w);
      begin repeat (k) @(posedge PCLK); #1; spi_done = 1; spi_rx_data = rxd; @(posedge PCLK); #1; spi_done = 0; end
    join
    m_rx[0] = rxd[7:0]; m_rx[1] = rxd[15:8];
    if (w_op) m_tx[idx] = wd;
    tests++; if (w != k - 1) begin fails++; $display("FAIL %s_waits: got %0d need %0d", nm, w, k - 1); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL %s_err: got %b need 0", nm, e); end
    if (!w_op) begin
      tests++; if (rd !== model_rd(idx)) begin fails++; $display("FAIL %s_data: got %h need %h", nm, rd, model_rd(idx)); end
    end else begin
      tests++; if (spi_tx_data !== {m_tx[1], m_tx[0]})
        begin fails++; $display("FAIL %s_tx: got %h need %h", nm, spi_tx_data, {m_tx[1], m_tx[0]}); end
    end
  endtask

  task automatic test_done_in_start();
    logic [DW-1:0] rd; logic e; int w; logic [15:0] d;
    d = 16'($urandom);
    apb(1, sel_of(1), 0, m_tx[1], rd, e, w);
    spi_complete(d);
    apb(0, sel_of(3), 0, 0, rd, e, w);
    tests++; if (rd !== d[15:8] || w != 0)
      begin fails++; $display("FAIL done_in_start: got rd=%h waits=%0d need %h/0", rd, w, d[15:8]); end
  endtask

  task automatic test_tx_read_busy();
    logic [DW-1:0] rd; logic e; int w;
    apb(1, sel_of(1), 0, m_tx[1], rd, e, w);
    apb(0, sel_of(0), 0, 0, rd, e, w);
    tests++; if (rd !== m_tx[0] || w != 0)
      begin fails++; $display("FAIL tx_read_busy: got rd=%h waits=%0d need %h/0", rd, w, m_tx[0]); end
    spi_complete(16'($urandom));
  endtask

  task automatic test_errors();
    logic [DW-1:0] rd; logic e; int w;
    apb(1, sel_of(3), 0, 8'hFF, rd, e, w);
    tests++; if (e !== 1'b1 || w != 0) begin fails++; $display("FAIL err_rx_write: got err=%b waits=%0d need 1/0", e, w); end
    apb(0, sel_of(3), 0, 0, rd, e, w);
    tests++; if (rd !== m_rx[1]) begin fails++; $display("FAIL err_rx_unchanged: got %h need %h", rd, m_rx[1]); end
    apb(0, sel_of(0), 1, 0, rd, e, w);
    tests++; if (e !== 1'b1 || rd !== 8'h00) begin fails++; $display("FAIL err_dec: got err=%b rd=%h need 1/00", e, rd); end
    apb(1, 6'b010011, 0, 8'h77, rd, e, w);
    tests++; if (e !== 1'b1 || spi_tx_data !== {m_tx[1], m_tx[0]})
      begin fails++; $display("FAIL err_multihot: got err=%b tx=%h need 1/%h", e, spi_tx_data, {m_tx[1], m_tx[0]}); end
    for (int b = 0; b < 2; b++) begin
      spi_busy = b[0];
      apb(0, '0, 0, 0, rd, e, w);
      tests++; if (rd !== {7'd0, b[0]} || e !== 1'b0)
        begin fails++; $display("FAIL status_busy%0d: got rd=%h err=%b need %h/0", b, rd, e, b); end
    end
    spi_busy = 0;
  endtask

  task automatic test_reset_midxfer();
    logic [DW-1:0] rd; logic e; int w;
    apb(1, sel_of(1), 0, 8'h5E, rd, e, w);
    repeat (2) @(posedge PCLK); #1;
    PRESET = 1; @(posedge PCLK); #1; PRESET = 0;
    model_reset();
    start_cnt = 0;
    spi_rx_data = 16'hBEEF; spi_done = 1; @(posedge PCLK); #1; spi_done = 0;
    repeat (3) @(posedge PCLK); #1;
    tests++; if (start_cnt != 0) begin fails++; $display("FAIL midrst_start: got %0d pulses need 0", start_cnt); end
    for (int idx = 2; idx < 4; idx++) begin
      apb(0, sel_of(idx), 0, 0, rd, e, w);
      tests++; if (rd !== 8'h00 || w != 0)
        begin fails++; $display("FAIL midrst_rx%0d: got rd=%h waits=%0d need 00/0", idx, rd, w); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, wd; logic e; int w, idx; logic op;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 3); op = 1'($urandom); wd = 8'($urandom);
      apb(op, sel_of(idx), 0, wd, rd, e, w);
      if (op) begin
        tests++; if (e !== (idx >= NTX)) begin fails++; $display("FAIL rnd_werr%0d: got %b need %b", n, e, idx >= NTX); end
        if (idx < NTX) m_tx[idx] = wd;
        if (idx == 1) begin repeat ($urandom_range(0, 3)) @(posedge PCLK); #1; spi_complete(16'($urandom)); end
      end else begin
        tests++; if (rd !== model_rd(idx) || e !== 1'b0)
          begin fails++; $display("FAIL rnd_read%0d: idx %0d got %h/%b need %h/0", n, idx, rd, e, model_rd(idx)); end
      end
    end
  endtask

`ifdef SPI_REGS_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] rd; logic e; int w;
    apb(1, sel_of(1), 0, m_tx[1], rd, e, w);
    apb(0, sel_of(2), 0, 0, rd, e, w);
    tests++; if (w != 255 || e !== 1'b1 || rd !== 8'h00)
      begin fails++; $display("FAIL timeout: got waits=%0d err=%b rd=%h need 255/1/00", w, e, rd); end
    spi_complete(16'($urandom));
  endtask
`endif

  initial begin
    test_reset();
    test_launch();
    test_stall(0, 2, 16'h5AC3, 4, "stall_rd2");
    for (int r = 0; r < 3; r++) test_stall(0, 2 + r % 2, 16'($urandom), $urandom_range(3, 10), "stall_rdrnd");
    test_stall(1, 0, 16'($urandom), $urandom_range(3, 10), "stall_wr0");
    test_done_in_start();
    test_tx_read_busy();
    test_errors();
    test_reset_midxfer();
    test_random();
`ifdef SPI_REGS_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apb_spi_regs.md
Name: apb_spi_regs

Overview:
APB register bank for the SPI task, directly downstream of the APB address decoder. Consumes the decoder's one-hot register select and error flag. Holds TX data registers and RX data registers, launches SPI transfers, and inserts APB wait states while a transfer is in flight. Feeds the SPI shift engine and returns its received data to the APB bus.

Parameters:
DWIDTH, 8, APB data width and width of each data register
REGN, 6, decoder select width: data-register indices 0..REGN-3, plus TX-group flag at REGN-2 and RX-group flag at REGN-1
REGTX_ADDR_OFFSET, 1, last TX register index; NTX = REGTX_ADDR_OFFSET+1; NRX = REGN-2-NTX (default 2 TX, 2 RX)

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous reset, active-high
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PWDATA  in  DWIDTH  APB write data
pselw  in  REGN  one-hot register select plus group flags, from decoder
dec_err  in  1  decoder address error
PRDATA  out  DWIDTH  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error, valid when PREADY=1 in access phase
spi_tx_data  out  NTX*DWIDTH  TX registers concatenated, reg 0 at LSBs
spi_start  out  1  one-cycle transfer launch pulse
spi_busy  in  1  SPI engine busy (status only)
spi_done  in  1  one-cycle transfer-complete pulse
spi_rx_data  in  NRX*DWIDTH  received data, RX reg NTX at LSBs

Behaviour:
- Reset (synchronous PRESET=1): all TX/RX regs =0, spi_start=0, PREADY=1, PSLVERR=0, PRDATA=0, both FSMs idle. A reset mid-transfer abandons the transfer; a later spi_done is ignored unless a new transfer was started.
- Access cycle: PSEL=1 and PENABLE=1. Setup cycles (PENABLE=0) have no side effects.
- SPI FSM states:
  - S_IDLE -> S_START on a committed write to index REGTX_ADDR_OFFSET (the launch register).
  - S_START: spi_start=1 for exactly one cycle, then -> S_BUSY.
  - S_BUSY: waits for spi_done.
  - spi_done sampled in S_START or S_BUSY: load all RX regs from spi_rx_data at that edge, then -> S_IDLE.
  - spi_done in S_IDLE is ignored.
- Stall rule: an access stalls while the SPI FSM is not S_IDLE and either:
  - the access is a read with pselw[REGN-1]=1, or
  - the access is a write with pselw[REGN-2]=1.
  - During a stall, PREADY=0 (combinational on the access cycle) and no register changes. The cycle after the FSM returns to S_IDLE, PREADY=1 and the access completes.
- Completion, zero-wait when not stalled. PREADY=1 in the access cycle; the write commits at that edge. PRDATA (combinational mux on pselw) is valid the same cycle.
- Errors (PREADY=1, PSLVERR=1, no state change, PRDATA=0):
  - dec_err=1
  - write with pselw[REGN-1]=1 (RX is read-only)
  - pselw data field not one-hot
- Reads of TX regs return the stored value and never stall.
- spi_busy is not used for control. It is readable as PRDATA bit 0 when the access has dec_err=0 and pselw=0. In that case PSLVERR=0 and all other PRDATA bits are 0.
- PSLVERR=0 whenever PREADY=0 or no access is in progress.

Optional Feature:
Macro SPI_REGS_TIMEOUT_EN.
- Defined: an 8-bit counter runs while an access is stalled. On reaching 255, the access completes with PREADY=1, PSLVERR=1, PRDATA=0 and no write commit. The counter clears on access completion and on reset.
- Undefined: stalls last indefinitely until the SPI FSM returns to S_IDLE.

Test Plan:
- Reset then read TX reg 0 and RX reg 2 -> PRDATA=0x00, PSLVERR=0, PREADY=1 zero-wait.
- Write 0xA5 to reg 0, then 0x3C to reg 1 -> spi_start pulses exactly once, one cycle after the reg-1 write edge; spi_tx_data=0x3CA5.
- Start a transfer and read reg 2 -> PREADY=0 until spi_done with spi_rx_data=0x5AC3; next cycle PREADY=1 and PRDATA=0xC3.
- Write to reg 3 -> PSLVERR=1, RX unchanged. Access with dec_err=1 -> PSLVERR=1, PRDATA=0.
- Assert PRESET while in S_BUSY, then pulse spi_done -> RX regs stay 0, spi_start stays 0.
- With SPI_REGS_TIMEOUT_EN, hold spi_done low during a stalled RX read -> after 255 stall cycles PREADY=1, PSLVERR=1.
